// File: rtl/ram_cb_16k.sv
// Circular 16k-sample history buffer: one write per wen, four consecutive-delay reads per clock.
// Optional RAM_CB_ZERO_FILL_EN masks never-filled delays to zero after reset.
module ram_cb_16k #(
   parameter int DW = 18,
   parameter int AW = 12
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DW-1:0]     din,
   input  logic              wen,
   input  logic [AW-1:0]     addrin,
   output logic [4*DW-1:0]   dout
);

   localparam int PW   = AW + 2;
   localparam int ROWS = 1 << AW;

   logic [PW-1:0] r_wp;
   logic [PW-1:0] w_newest;
   logic [PW-1:0] w_base;
   logic [1:0]    r_rot;
   logic [3:0]    w_lane_zero;
   logic [DW-1:0] w_bank_q [4];

   assign w_newest = r_wp - PW'(1);
   // w_base is the absolute index of lane 0 (delay 4a); lanes k sit at w_base-k.
   assign w_base   = w_newest - {addrin, 2'b00};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wp  <= '0;
         r_rot <= '0;
      end else begin
         r_rot <= w_base[1:0];
         if (wen) begin
            r_wp <= r_wp + PW'(1);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bank
         logic [DW-1:0] r_mem [ROWS];
         logic [DW-1:0] r_q;
         logic [AW-1:0] w_row;

         // Banks below or at lane 0's bank share its row; higher banks belong to the previous row.
         assign w_row = (2'(gi) <= w_base[1:0]) ? w_base[PW-1:2]
                                                : w_base[PW-1:2] - AW'(1);

         always_ff @(posedge clock) begin
            if (wen && (r_wp[1:0] == 2'(gi))) begin
               r_mem[r_wp[PW-1:2]] <= din;
            end
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               r_q <= '0;
            end else begin
               r_q <= r_mem[w_row];
            end
         end

         assign w_bank_q[gi] = r_q;
      end

      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [1:0] w_sel;
         assign w_sel = r_rot - 2'(gi);
         assign dout[4*DW-1-DW*gi -: DW] = w_lane_zero[gi] ? '0 : w_bank_q[w_sel];
      end
   endgenerate

`ifdef RAM_CB_ZERO_FILL_EN
   localparam logic [PW:0] CNT_MAX = {1'b1, {PW{1'b0}}};

   logic [PW:0] r_cnt;
   logic [3:0]  r_lane_zero;
   logic [3:0]  w_zero_next;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_zero
         logic [PW-1:0] w_delay;
         assign w_delay         = {addrin, 2'b00} + PW'(gi);
         assign w_zero_next[gi] = ({1'b0, w_delay} >= r_cnt);
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_lane_zero <= '0;
      end else begin
         r_lane_zero <= w_zero_next;
         if (wen && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + (PW+1)'(1);
         end
      end
   end

   assign w_lane_zero = r_lane_zero;
`else
   assign w_lane_zero = 4'b0000;
`endif

endmodule

// File: tb/tb_ram_cb_16k.sv
// Bench for ram_cb_16k: array-based history model checked every cycle plus literal test-plan points.
module tb_ram_cb_16k;
   localparam int DW    = 18;
   localparam int AW    = 12;
   localparam int DEPTH = 16384;
   localparam int MASK  = (1 << DW) - 1;
`ifdef RAM_CB_ZERO_FILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif

   logic            clock  = 1'b0;
   logic            reset  = 1'b0;
   logic            wen    = 1'b0;
   logic [DW-1:0]   din    = '0;
   logic [AW-1:0]   addrin = '0;
   logic [4*DW-1:0] dout;

   int checks   = 0;
   int failures = 0;

   ram_cb_16k #(.DW(DW), .AW(AW)) dut (
      .clock  (clock),
      .reset  (reset),
      .din    (din),
      .wen    (wen),
      .addrin (addrin),
      .dout   (dout)
   );

   always #5 clock = ~clock;

   // Model: flat sample array indexed by absolute position, plus a written flag per slot.
   int m_mem [DEPTH];
   bit m_wr  [DEPTH];
   int m_wp  = 0;
   int m_cnt = 0;
   int exp_v [4] = '{0, 0, 0, 0};
   bit exp_k [4] = '{0, 0, 0, 0};

   always @(posedge clock or posedge reset) begin
      int n;
      if (reset) begin
         m_wp  <= 0;
         m_cnt <= 0;
         for (int k = 0; k < 4; k++) begin
            exp_v[k] <= 0;
            exp_k[k] <= 1'b1;
         end
      end else begin
         n = (m_wp + DEPTH - 1) % DEPTH;
         for (int k = 0; k < 4; k++) begin
            int d;
            int idx;
            d   = 4 * int'(addrin) + k;
            idx = ((n - d) % DEPTH + DEPTH) % DEPTH;
            if (ZF && d >= m_cnt) begin
               exp_v[k] <= 0;
               exp_k[k] <= 1'b1;
            end else begin
               exp_v[k] <= m_mem[idx];
               exp_k[k] <= m_wr[idx];
            end
         end
         if (wen) begin
            m_mem[m_wp] <= int'(din);
            m_wr[m_wp]  <= 1'b1;
            m_wp        <= (m_wp + 1) % DEPTH;
            if (m_cnt < DEPTH) m_cnt <= m_cnt + 1;
         end
      end
   end

   function automatic int lane(input logic [4*DW-1:0] v, input int k);
      return int'(v[4*DW-1-DW*k -: DW]);
   endfunction

   always @(negedge clock) begin
      bit any;
      int bad;
      any = 1'b0;
      bad = -1;
      for (int k = 0; k < 4; k++) begin
         if (exp_k[k]) begin
            any = 1'b1;
            if (bad < 0 && lane(dout, k) != exp_v[k]) bad = k;
         end
      end
      if (any) begin
         checks++;
         if (bad >= 0) begin
            failures++;
            $display("FAIL model_cmp t=%0t lane%0d got=%0d want=%0d", $time, bad, lane(dout, bad), exp_v[bad]);
         end
      end
   end

   task automatic tick;
      @(posedge clock);
      #2;
   endtask

   task automatic chk(input string nm, input int e0, input int e1, input int e2, input int e3,
                      input bit [3:0] m);
      int e [4];
      e = '{e0, e1, e2, e3};
      for (int k = 0; k < 4; k++) begin
         if (m[k]) begin
            checks++;
            if (lane(dout, k) != e[k]) begin
               failures++;
               $display("FAIL %s lane%0d got=%0d want=%0d", nm, k, lane(dout, k), e[k]);
            end
         end
      end
   endtask

   task automatic wr(input int v);
      din = DW'(v & MASK);
      wen = 1'b1;
      tick();
      wen = 1'b0;
   endtask

   task automatic do_reset;
      tick();
      reset = 1'b1;
      #1;
      chk("reset_state", 0, 0, 0, 0, 4'hF);
      tick();
      reset = 1'b0;
   endtask

   initial begin
      // Test 1: five samples, newest group and partially filled next group
      do_reset();
      for (int v = 1; v <= 5; v++) wr(v);
      addrin = '0;
      tick();
      chk("t1_a0", 5, 4, 3, 2, 4'hF);
      addrin = AW'(1);
      tick();
      chk("t1_a1", 1, 0, 0, 0, {ZF, ZF, ZF, 1'b1});
      $display("t1 done checks=%0d", checks);

      // Test 2: pointer wrap after 16387 writes
      do_reset();
      for (int v = 1; v <= 16387; v++) wr(v);
      addrin = '0;
      tick();
      chk("t2_a0", 16387, 16386, 16385, 16384, 4'hF);
      addrin = AW'(4095);
      tick();
      chk("t2_a4095", 7, 6, 5, 4, 4'hF);
      $display("t2 done checks=%0d", checks);

      // Test 3: read-before-write on the same edge
      do_reset();
      for (int v = 1; v <= 8; v++) wr(v);
      din    = DW'(9);
      wen    = 1'b1;
      addrin = '0;
      tick();
      wen = 1'b0;
      chk("t3_same", 8, 7, 6, 5, 4'hF);
      tick();
      chk("t3_next", 9, 8, 7, 6, 4'hF);
      $display("t3 done checks=%0d", checks);

      // Test 4: full sweep with sparse writes
      for (int i = 0; i < 4096; i++) begin
         addrin = AW'(i);
         wen    = (i % 2083 == 0);
         din    = DW'(100 + i);
         tick();
         if (i == 0) chk("t4_latency", 9, 8, 7, 6, 4'hF);
      end
      wen = 1'b0;
      $display("t4 done checks=%0d", checks);

      // Test 5: asynchronous reset in the middle of a sweep
      for (int i = 0; i < 4096; i++) begin
         addrin = AW'(i);
         tick();
         if (i == 1000) begin
            reset = 1'b1;
            #1;
            chk("t5_async_reset", 0, 0, 0, 0, 4'hF);
            #1;
            reset = 1'b0;
            break;
         end
      end
      wr(42);
      addrin = '0;
      tick();
      chk("t5_after_reset", 42, 0, 0, 0, {ZF, ZF, ZF, 1'b1});
      $display("t5 done checks=%0d", checks);

      // Test 6: wen held high for four consecutive cycles
      wen = 1'b1;
      for (int v = 10; v <= 13; v++) begin
         din = DW'(v);
         tick();
      end
      wen    = 1'b0;
      addrin = '0;
      tick();
      chk("t6_burst", 13, 12, 11, 10, 4'hF);
      tick();
      $display("t6 done checks=%0d", checks);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
